// File: rtl/sw_mmio.sv
// Switch/button MMIO responder: 2-flop sync, tick debounce, sticky press events, maskable IRQ.
// Optional press counter at offset 4 when SW_MMIO_CNT_EN is defined.

module sw_mmio_deb (
    input  logic CLK,
    input  logic RSTN,
    input  logic tick,
    input  logic pad,
    output logic stable,
    output logic rise
);
    logic meta, sync, prev;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            prev   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta <= pad;
            sync <= meta;
            if (tick) begin
                prev <= sync;
                if (sync == prev) stable <= sync;
            end
        end
    end

    // stable goes 0->1 at this edge
    assign rise = tick & (sync == prev) & sync & ~stable;
endmodule

module sw_mmio #(
    parameter int DEB_CYCLES = 750000,
    parameter int NSW        = 16,
    parameter int NBTN       = 5
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            SEL,
    input  logic            RE,
    input  logic            WE,
    input  logic [2:0]      MADDR,
    input  logic [31:0]     MDATAO,
    input  logic [3:0]      MWSTB,
    output logic [31:0]     RDATA,
    input  logic [NSW-1:0]  SW_IN,
    input  logic [NBTN-1:0] BTN_IN,
    output logic            IRQ
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic [CW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RSTN)     tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + CW'(1);
    end

    logic [NSW-1:0]  stable_sw, unused_sw_rise;
    logic [NBTN-1:0] stable_btn, btn_rise;

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        sw_mmio_deb u_deb (
            .CLK    (CLK),
            .RSTN   (RSTN),
            .tick   (tick),
            .pad    (SW_IN[i]),
            .stable (stable_sw[i]),
            .rise   (unused_sw_rise[i])
        );
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        sw_mmio_deb u_deb (
            .CLK    (CLK),
            .RSTN   (RSTN),
            .tick   (tick),
            .pad    (BTN_IN[i]),
            .stable (stable_btn[i]),
            .rise   (btn_rise[i])
        );
    end

    logic        wr, rd;
    logic [31:0] bmask, wbits, rd_val;
    logic        unused_ok;

    assign wr        = SEL & WE;
    assign rd        = SEL & RE;
    assign bmask     = {{8{MWSTB[3]}}, {8{MWSTB[2]}}, {8{MWSTB[1]}}, {8{MWSTB[0]}}};
    assign wbits     = MDATAO & bmask;
    assign unused_ok = ^{wbits, bmask};

    logic [NBTN-1:0] evt, mask, evt_nx, mask_nx;

    // W1C applied first so a same-cycle press still lands
    always_comb begin
        evt_nx  = evt;
        mask_nx = mask;
        if (wr && MADDR == 3'd2) evt_nx  = evt & ~wbits[NBTN-1:0];
        if (wr && MADDR == 3'd3) mask_nx = (mask & ~bmask[NBTN-1:0]) | wbits[NBTN-1:0];
        evt_nx = evt_nx | btn_rise;
    end

`ifdef SW_MMIO_CNT_EN
    logic [31:0] cnt, npress;

    always_comb begin
        npress = '0;
        for (int i = 0; i < NBTN; i++) npress = npress + 32'(btn_rise[i]);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN)                               cnt <= '0;
        else if (wr && MADDR == 3'd4 && |MWSTB)  cnt <= '0;
        else                                     cnt <= cnt + npress;
    end
`endif

    always_comb begin
        rd_val = '0;
        case (MADDR)
            3'd0: rd_val[NSW-1:0]  = stable_sw;
            3'd1: rd_val[NBTN-1:0] = stable_btn;
            3'd2: rd_val[NBTN-1:0] = evt;
            3'd3: rd_val[NBTN-1:0] = mask;
`ifdef SW_MMIO_CNT_EN
            3'd4: rd_val = cnt;
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            evt   <= '0;
            mask  <= '0;
            IRQ   <= 1'b0;
            RDATA <= '0;
        end else begin
            evt   <= evt_nx;
            mask  <= mask_nx;
            IRQ   <= |(evt_nx & mask_nx);
            RDATA <= rd ? rd_val : 32'h0;
        end
    end
endmodule

// File: tb/tb_sw_mmio.sv
// Self-checking bench for sw_mmio: directed scenarios plus random traffic against a reference model.
module tb_sw_mmio;
    localparam int DEB  = 4;
    localparam int NSW  = 16;
    localparam int NBTN = 5;

    logic            CLK = 1'b0;
    logic            RSTN, SEL, RE, WE;
    logic [2:0]      MADDR;
    logic [31:0]     MDATAO, RDATA;
    logic [3:0]      MWSTB;
    logic [NSW-1:0]  SW_IN;
    logic [NBTN-1:0] BTN_IN;
    logic            IRQ;

    int nchk = 0;
    int nfail = 0;

    sw_mmio #(.DEB_CYCLES(DEB), .NSW(NSW), .NBTN(NBTN)) dut (
        .CLK(CLK), .RSTN(RSTN), .SEL(SEL), .RE(RE), .WE(WE), .MADDR(MADDR),
        .MDATAO(MDATAO), .MWSTB(MWSTB), .RDATA(RDATA), .SW_IN(SW_IN),
        .BTN_IN(BTN_IN), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    // Reference model: pads seen two edges late, debounce samples every DEB cycles since reset.
    int              m_n;
    logic [NSW-1:0]  m_swp1, m_swp2, m_swprev, m_sw;
    logic [NBTN-1:0] m_btp1, m_btp2, m_btprev, m_bt, m_evt, m_mask;
    logic [31:0]     m_rdata, m_cnt;
    logic            m_irq;

    always @(posedge CLK) begin : model
        logic [NSW-1:0]  sw_s, sw_new;
        logic [NBTN-1:0] bt_s, bt_new, rise, e, mk, wd, bm5;
        logic [31:0]     bm, rdv;
        logic            tk;
        if (!RSTN) begin
            m_n <= 0; m_swp1 <= '0; m_swp2 <= '0; m_swprev <= '0; m_sw <= '0;
            m_btp1 <= '0; m_btp2 <= '0; m_btprev <= '0; m_bt <= '0;
            m_evt <= '0; m_mask <= '0; m_rdata <= '0; m_cnt <= '0; m_irq <= 1'b0;
        end else begin
            tk = (m_n % DEB) == DEB - 1;
            sw_s = m_swp2; bt_s = m_btp2;
            sw_new = m_sw; bt_new = m_bt;
            if (tk) begin
                for (int i = 0; i < NSW; i++)  if (sw_s[i] == m_swprev[i]) sw_new[i] = sw_s[i];
                for (int i = 0; i < NBTN; i++) if (bt_s[i] == m_btprev[i]) bt_new[i] = bt_s[i];
                m_swprev <= sw_s; m_btprev <= bt_s;
            end
            rise = bt_new & ~m_bt;
            bm = {{8{MWSTB[3]}}, {8{MWSTB[2]}}, {8{MWSTB[1]}}, {8{MWSTB[0]}}};
            bm5 = bm[NBTN-1:0];
            wd = MDATAO[NBTN-1:0];
            rdv = 32'h0;
            if (SEL && RE) begin
                case (MADDR)
                    3'd0: rdv[NSW-1:0]  = m_sw;
                    3'd1: rdv[NBTN-1:0] = m_bt;
                    3'd2: rdv[NBTN-1:0] = m_evt;
                    3'd3: rdv[NBTN-1:0] = m_mask;
`ifdef SW_MMIO_CNT_EN
                    3'd4: rdv = m_cnt;
`endif
                    default: rdv = 32'h0;
                endcase
            end
            e = m_evt; mk = m_mask;
            if (SEL && WE && MADDR == 3'd2) e = e & ~(wd & bm5);
            if (SEL && WE && MADDR == 3'd3) mk = (mk & ~bm5) | (wd & bm5);
            e = e | rise;
            if (SEL && WE && MADDR == 3'd4 && MWSTB != 4'h0) m_cnt <= 32'h0;
            else m_cnt <= m_cnt + 32'($countones(rise));
            m_n <= m_n + 1;
            m_swp2 <= m_swp1; m_swp1 <= SW_IN;
            m_btp2 <= m_btp1; m_btp1 <= BTN_IN;
            m_sw <= sw_new; m_bt <= bt_new;
            m_evt <= e; m_mask <= mk;
            m_irq <= |(e & mk);
            m_rdata <= rdv;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus(input logic s, input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] st);
        SEL = s; RE = r; WE = w; MADDR = a; MDATAO = d; MWSTB = st;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        RSTN = 1'b0; idle(); SW_IN = '0; BTN_IN = '0;
        step(3);
        nchk++;
        if (RDATA !== 32'h0 || IRQ !== 1'b0) begin
            nfail++; $display("FAIL reset_out: RDATA/IRQ %h/%b want 0/0", RDATA, IRQ);
        end
        RSTN = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus(1'b1, 1'b1, 1'b0, 3'(a), 32'h0, 4'h0); step();
            nchk++;
            if (RDATA !== 32'h0) begin
                nfail++; $display("FAIL reset_reg%0d: got %h want 0", a, RDATA);
            end
        end
        idle();
    endtask

    task automatic test_switch();
        SW_IN = 16'h00A5; idle();
        for (int i = 0; i < 10; i++) begin
            step();
            nchk++;
            if (RDATA !== 32'h0 || {RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL sw_noread c%0d: RDATA %h want 0", i, RDATA);
            end
        end
        bus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0000_00A5) begin
            nfail++; $display("FAIL sw_read: got %h want 000000a5", RDATA);
        end
        idle();
    endtask

    task automatic test_glitch();
        BTN_IN = 5'b00100; step();
        BTN_IN = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            nchk++;
            if ({RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL glitch_model c%0d: %h/%b want %h/%b", i, RDATA, IRQ, m_rdata, m_irq);
            end
        end
        bus(1'b1, 1'b1, 1'b0, 3'd1, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL glitch_btn: got %h want 0", RDATA); end
        bus(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL glitch_evt: got %h want 0", RDATA); end
        idle();
    endtask

    task automatic test_btn_irq();
        bus(1'b1, 1'b0, 1'b1, 3'd3, 32'h4, 4'hF); step();
        idle(); BTN_IN = 5'b00100;
        for (int i = 0; i < 12; i++) begin
            step();
            nchk++;
            if ({RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL press_model c%0d: %h/%b want %h/%b", i, RDATA, IRQ, m_rdata, m_irq);
            end
        end
        BTN_IN = '0;
        nchk++;
        if (IRQ !== 1'b1) begin nfail++; $display("FAIL press_irq: got %b want 1", IRQ); end
        bus(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h4) begin nfail++; $display("FAIL press_evt: got %h want 4", RDATA); end
        bus(1'b1, 1'b0, 1'b1, 3'd2, 32'h4, 4'h1); step();
        nchk++;
        if (IRQ !== 1'b0) begin nfail++; $display("FAIL w1c_irq: got %b want 0", IRQ); end
        bus(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL w1c_evt: got %h want 0", RDATA); end
        idle(); step(12);
    endtask

    task automatic test_set_wins();
        int hits = 0;
        BTN_IN = 5'b00001;
        bus(1'b1, 1'b1, 1'b1, 3'd2, 32'h1, 4'h1);
        for (int i = 0; i < 14; i++) begin
            step();
            if (RDATA[0] === 1'b1) hits++;
            nchk++;
            if ({RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL setwin_model c%0d: %h/%b want %h/%b", i, RDATA, IRQ, m_rdata, m_irq);
            end
        end
        nchk++;
        if (hits !== 1) begin nfail++; $display("FAIL set_wins: evt0 seen %0d times want 1", hits); end
        idle(); BTN_IN = '0; step(12);
    endtask

    task automatic test_mask_rw();
        bus(1'b1, 1'b0, 1'b1, 3'd3, 32'h3, 4'hF); step();
        bus(1'b1, 1'b1, 1'b1, 3'd3, 32'h1F, 4'hF); step();
        nchk++;
        if (RDATA !== 32'h3) begin nfail++; $display("FAIL mask_rdwr: got %h want 3", RDATA); end
        bus(1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h1F) begin nfail++; $display("FAIL mask_new: got %h want 1f", RDATA); end
        bus(1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 4'h0); step();
        bus(1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h1F) begin nfail++; $display("FAIL mask_nostb: got %h want 1f", RDATA); end
        bus(1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 4'hE); step();
        bus(1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h1F) begin nfail++; $display("FAIL mask_lane: got %h want 1f", RDATA); end
        bus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 4'hF); step();
        bus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'hA5) begin nfail++; $display("FAIL sw_ro: got %h want a5", RDATA); end
        bus(1'b0, 1'b1, 1'b1, 3'd3, 32'h0, 4'hF); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL nosel_rd: got %h want 0", RDATA); end
        bus(1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h1F) begin nfail++; $display("FAIL nosel_wr: got %h want 1f", RDATA); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 8; a++) begin
            bus(1'b1, 1'b1, 1'b0, 3'(a), 32'hFFFF_FFFF, 4'h0); step();
            nchk++;
            if ({RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL b2b_a%0d: %h/%b want %h/%b", a, RDATA, IRQ, m_rdata, m_irq);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        BTN_IN = 5'b00010; SW_IN = 16'hFFFF; idle(); step(5);
        RSTN = 1'b0; step(2);
        nchk++;
        if (RDATA !== 32'h0 || IRQ !== 1'b0) begin
            nfail++; $display("FAIL rstmid_out: RDATA/IRQ %h/%b want 0/0", RDATA, IRQ);
        end
        RSTN = 1'b1;
        bus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL rstmid_sw0: got %h want 0", RDATA); end
        idle();
        for (int i = 0; i < 12; i++) begin
            step();
            nchk++;
            if ({RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL rstmid_model c%0d: %h/%b want %h/%b", i, RDATA, IRQ, m_rdata, m_irq);
            end
        end
        bus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'hFFFF) begin nfail++; $display("FAIL rstmid_sw: got %h want ffff", RDATA); end
        bus(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h2) begin nfail++; $display("FAIL held_evt: got %h want 2", RDATA); end
        BTN_IN = '0;
        bus(1'b1, 1'b0, 1'b1, 3'd2, 32'h1F, 4'hF); step();
        idle(); step(12);
    endtask

    task automatic test_cnt();
`ifdef SW_MMIO_CNT_EN
        bus(1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 4'h1); step();
        idle();
        for (int p = 0; p < 3; p++) begin
            BTN_IN = 5'b01000; step(12);
            BTN_IN = '0; step(12);
        end
        bus(1'b1, 1'b1, 1'b0, 3'd4, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h3 || RDATA !== m_rdata) begin
            nfail++; $display("FAIL cnt3: got %h want 3 (model %h)", RDATA, m_rdata);
        end
        bus(1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 4'h8); step();
        bus(1'b1, 1'b1, 1'b0, 3'd4, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL cnt_clr: got %h want 0", RDATA); end
`else
        bus(1'b1, 1'b0, 1'b1, 3'd4, 32'h1234, 4'hF); step();
        bus(1'b1, 1'b1, 1'b0, 3'd4, 32'h0, 4'h0); step();
        nchk++;
        if (RDATA !== 32'h0) begin nfail++; $display("FAIL off4: got %h want 0", RDATA); end
`endif
        idle();
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) SW_IN = NSW'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                b = $urandom_range(0, NBTN - 1);
                BTN_IN[b] = ~BTN_IN[b];
            end
            RSTN = ($urandom_range(0, 299) != 0);
            bus(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom),
                $urandom, 4'($urandom));
            step();
            nchk++;
            if ({RDATA, IRQ} !== {m_rdata, m_irq}) begin
                nfail++; $display("FAIL random c%0d: %h/%b want %h/%b", i, RDATA, IRQ, m_rdata, m_irq);
            end
        end
        RSTN = 1'b1; idle();
    endtask

    initial begin
        test_reset();
        test_switch();
        test_glitch();
        test_btn_irq();
        test_set_wins();
        test_mask_rw();
        test_back_to_back();
        test_reset_mid();
        test_cnt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
